// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the R-type CPU controllers: FSM states, ALU op codes,
// R-type funct values and the R-type opcode.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_NOR  = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLL  = 3'b111;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_SLL  = 6'b000000;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;

endpackage

// File: rtl/rtype_funct_decoder.sv
// Combinational R-type decoder: maps opcode/funct to ALU op, overflow-flag
// enable and shamt operand select; flags anything outside the table as illegal.
module rtype_funct_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       of_en,
    output logic       rs_shamt,
    output logic       legal
);

    always_comb begin
        alu_op   = ALU_AND;
        of_en    = 1'b0;
        rs_shamt = 1'b0;
        legal    = 1'b0;
        if (opcode == OPC_RTYPE) begin
            legal = 1'b1;
            case (funct)
                FN_ADD:  begin alu_op = ALU_ADD;  of_en = 1'b1; end
                FN_SUB:  begin alu_op = ALU_SUB;  of_en = 1'b1; end
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_XOR:  alu_op = ALU_XOR;
                FN_NOR:  alu_op = ALU_NOR;
                FN_SLTU: alu_op = ALU_SLTU;
                FN_SLLV: begin alu_op = ALU_SLL;  of_en = 1'b1; end
                FN_JR:   begin alu_op = ALU_ADD;  of_en = 1'b1; end
                FN_SLL:  begin alu_op = ALU_SLL;  of_en = 1'b1; rs_shamt = 1'b1; end
                default: legal = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/rtype_multicycle_ctrl.sv
// Multi-cycle IF/ID/EX/WB sequencer for the R-type datapath with free-run,
// single-step and halt-on-illegal behaviour.
module rtype_multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned IF_CYCLES = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clka,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic [31:0]      inst,
    output logic             pc_write,
    output logic             ir_write,
    output logic             ab_write,
    output logic             alu_write,
    output logic             write_reg,
    output logic             set_zf,
    output logic             set_of,
    output logic [2:0]       alu_op,
    output logic             rs_shamt,
    output logic             illegal,
    output logic             busy,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] IF_LAST = 3'(IF_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] if_cnt;
    logic       step_q;
    logic [5:0] opcode_q, funct_q;
    logic [2:0] alu_op_q;
    logic       rs_shamt_q, of_en_q;

    logic [2:0] dec_alu_op;
    logic       dec_of_en, dec_rs_shamt, dec_legal;
    logic       if_last, step_edge;
    logic       unused_inst;

    assign unused_inst = ^inst[25:6];

    rtype_funct_decoder u_dec (
        .opcode   (opcode_q),
        .funct    (funct_q),
        .alu_op   (dec_alu_op),
        .of_en    (dec_of_en),
        .rs_shamt (dec_rs_shamt),
        .legal    (dec_legal)
    );

    assign if_last   = (state_q == S_IF) && (if_cnt == IF_LAST);
    assign step_edge = step && !step_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (run || step_edge) state_d = S_IF;
            S_IF:    if (if_last) state_d = S_ID;
            S_ID:    state_d = dec_legal ? S_EX : S_HALT;
            S_EX:    state_d = S_WB;
            S_WB:    state_d = run ? S_IF : S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Decode is visible combinationally in ID, then held from the registers through WB.
    always_comb begin
        pc_write  = if_last;
        ir_write  = if_last;
        ab_write  = (state_q == S_ID) && dec_legal;
        alu_write = (state_q == S_EX);
        set_zf    = (state_q == S_EX);
        set_of    = (state_q == S_EX) && of_en_q;
        write_reg = (state_q == S_WB);
        busy      = (state_q == S_IF) || (state_q == S_ID) ||
                    (state_q == S_EX) || (state_q == S_WB);
        alu_op    = (state_q == S_ID) ? dec_alu_op   : alu_op_q;
        rs_shamt  = (state_q == S_ID) ? dec_rs_shamt : rs_shamt_q;
        state     = state_q;
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state_q     <= S_IDLE;
            if_cnt      <= '0;
            step_q      <= 1'b0;
            opcode_q    <= '0;
            funct_q     <= '0;
            alu_op_q    <= ALU_AND;
            rs_shamt_q  <= 1'b0;
            of_en_q     <= 1'b0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step;
            if_cnt  <= ((state_q == S_IF) && !if_last) ? if_cnt + 3'd1 : '0;
            if (if_last) begin
                opcode_q <= inst[31:26];
                funct_q  <= inst[5:0];
            end
            if (state_q == S_ID) begin
                if (dec_legal) begin
                    alu_op_q   <= dec_alu_op;
                    rs_shamt_q <= dec_rs_shamt;
                    of_en_q    <= dec_of_en;
                end else begin
                    illegal <= 1'b1;
                end
            end
            if (state_q == S_WB)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rtype_multicycle_ctrl.sv
// Directed bench for rtype_multicycle_ctrl: walks legal, NOP, single-step,
// reset-in-EX, counter-wrap and illegal-halt cases against hand-computed values.
module tb_rtype_multicycle_ctrl;
    import cpu_ctrl_pkg::*;

    logic        clka = 1'b0;
    logic        rst, run, step;
    logic [31:0] inst;
    logic        pc_write, ir_write, ab_write, alu_write, write_reg, set_zf, set_of;
    logic [2:0]  alu_op;
    logic        rs_shamt, illegal, busy;
    logic [2:0]  state;
    logic [15:0] instr_count;
    logic [6:0]  strb;
    logic [15:0] exp_cnt;
    int          n_chk = 0;
    int          n_err = 0;

    rtype_multicycle_ctrl #(.IF_CYCLES(2), .CNT_W(16)) dut (
        .clka        (clka),
        .rst         (rst),
        .run         (run),
        .step        (step),
        .inst        (inst),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .ab_write    (ab_write),
        .alu_write   (alu_write),
        .write_reg   (write_reg),
        .set_zf      (set_zf),
        .set_of      (set_of),
        .alu_op      (alu_op),
        .rs_shamt    (rs_shamt),
        .illegal     (illegal),
        .busy        (busy),
        .state       (state),
        .instr_count (instr_count)
    );

    always #5 clka = ~clka;

    assign strb = {pc_write, ir_write, ab_write, alu_write, write_reg, set_zf, set_of};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clka);
        @(negedge clka);
    endtask

    // Caller leaves the DUT in IDLE with run/step/inst already driven.
    task automatic do_instr(input string tag, input logic [2:0] aop,
                            input logic ofe, input logic sh);
        cyc(); chk({tag, ".if1"}, {state, strb, busy}, {3'd1, 7'b0000000, 1'b1});
        cyc(); chk({tag, ".if2"}, {state, strb}, {3'd1, 7'b1100000});
        cyc(); chk({tag, ".id"},  {state, strb, alu_op, rs_shamt}, {3'd2, 7'b0010000, aop, sh});
        cyc(); chk({tag, ".ex"},  {state, strb, alu_op, rs_shamt}, {3'd3, 6'b000101, ofe, aop, sh});
        run  = 1'b0;
        step = 1'b0;
        cyc(); chk({tag, ".wb"},  {state, strb, alu_op, rs_shamt}, {3'd4, 7'b0000100, aop, sh});
        chk({tag, ".wbcnt"}, 32'(instr_count), 32'(exp_cnt));
        exp_cnt = exp_cnt + 16'd1;
        cyc(); chk({tag, ".idle"}, {state, strb, illegal, busy}, {3'd0, 7'b0, 1'b0, 1'b0});
        chk({tag, ".cnt"}, 32'(instr_count), 32'(exp_cnt));
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; step = 1'b0; inst = '0; exp_cnt = '0;
        cyc(); cyc();
        chk("reset", {state, strb, alu_op, rs_shamt, illegal, busy},
            {3'd0, 7'b0, 3'b000, 1'b0, 1'b0, 1'b0});
        chk("reset.cnt", 32'(instr_count), 32'd0);
        rst = 1'b0;

        // add $3,$1,$2 in free-run
        run = 1'b1; inst = 32'h0022_1820;
        do_instr("add", 3'b100, 1'b1, 1'b0);

        // and $3,$1,$2 via a single step pulse held 4 cycles
        step = 1'b1; inst = 32'h0022_1824;
        do_instr("step_and", 3'b000, 1'b0, 1'b0);
        cyc(); cyc();
        chk("step.once", {state, 16'(instr_count)}, {3'd0, 16'd2});

        // NOP: sll $0,$0,0
        run = 1'b1; inst = 32'h0000_0000;
        do_instr("nop", 3'b111, 1'b1, 1'b1);

        // sub, then reset asserted while in EX
        run = 1'b1; inst = 32'h0022_1822;
        cyc(); cyc(); cyc(); cyc();
        chk("rstex.ex", {state, strb, alu_op}, {3'd3, 7'b0001011, 3'b101});
        rst = 1'b1;
        cyc();
        chk("rstex.after", {state, strb, alu_op, rs_shamt, 16'(instr_count)},
            {3'd0, 7'b0, 3'b000, 1'b0, 16'd0});
        rst = 1'b0; run = 1'b0; exp_cnt = '0;
        cyc();

        // counter wrap from all-ones
        force dut.instr_count = 16'hFFFF;
        #1;
        release dut.instr_count;
        #1;
        chk("wrap.pre", 32'(instr_count), 32'h0000_FFFF);
        exp_cnt = 16'hFFFF;
        run = 1'b1; inst = 32'h0022_1820;
        do_instr("wrap", 3'b100, 1'b1, 1'b0);
        chk("wrap.zero", 32'(instr_count), 32'd0);

        // illegal opcode halts until reset
        run = 1'b1; inst = 32'h0800_0000;
        cyc(); chk("ill.if1", {state, strb}, {3'd1, 7'b0});
        cyc(); chk("ill.if2", {state, strb}, {3'd1, 7'b1100000});
        cyc(); chk("ill.id",  {state, strb, illegal}, {3'd2, 7'b0, 1'b0});
        cyc(); chk("ill.halt", {state, strb, illegal, busy}, {3'd5, 7'b0, 1'b1, 1'b0});
        for (int i = 0; i < 4; i++) begin
            step = i[0];
            cyc();
            chk("ill.hold", {state, strb, illegal, 16'(instr_count)}, {3'd5, 7'b0, 1'b1, 16'd0});
        end
        rst = 1'b1; run = 1'b0; step = 1'b0;
        cyc();
        chk("ill.rst", {state, strb, illegal, 16'(instr_count)}, {3'd0, 7'b0, 1'b0, 16'd0});
        rst = 1'b0;
        cyc();
        chk("ill.idle", {state, illegal}, {3'd0, 1'b0});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
